// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: operation mode encoding, default widths,
// and the pipeline-depth helper used by the add/sub unit.
package alu_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    // Slice widths below 1 are rejected at elaboration; 1 keeps the divide safe until then.
    function automatic int calc_stages(input int width, input int slice);
        return (slice < 1) ? 1 : width / slice;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SLICE-bit ripple-carry adder: one pipeline stage's worth of work.
module add_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[SLICE];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the ripple-carry adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit: WIDTH bits resolved SLICE bits per stage with the
// carry registered between stages; global-stall valid/ready handshake.
module pipe_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int STAGES = calc_stages(WIDTH, SLICE);
    localparam int LAST   = STAGES - 1;

    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("pipe_addsub: WIDTH must be a positive multiple of SLICE");
    end

    function automatic logic [WIDTH-1:0] put_slice(input logic [WIDTH-1:0] base,
                                                   input logic [SLICE-1:0] part,
                                                   input int              idx);
        logic [WIDTH-1:0] r;
        r = base;
        r[idx*SLICE +: SLICE] = part;
        return r;
    endfunction

    logic             stall;
    logic [WIDTH-1:0] b_cond;
    logic             cin_cond;

    // Stage registers, index k holds the result of stage k.
    logic [STAGES-1:0] vld_p;
    logic [WIDTH-1:0]  a_p   [STAGES];
    logic [WIDTH-1:0]  b_p   [STAGES];
    logic [WIDTH-1:0]  sum_p [STAGES];
    logic              cy_p  [STAGES];
    logic              sa_p  [STAGES];
    logic              sb_p  [STAGES];
    logic              ovf_p;
    logic              zero_p;

    // Per-stage combinational inputs and results.
    logic              v_in   [STAGES];
    logic [WIDTH-1:0]  a_in   [STAGES];
    logic [WIDTH-1:0]  b_in   [STAGES];
    logic [WIDTH-1:0]  s_in   [STAGES];
    logic              c_in   [STAGES];
    logic              sa_in  [STAGES];
    logic              sb_in  [STAGES];
    logic [WIDTH-1:0]  sum_nx [STAGES];
    logic              cy_nx  [STAGES];
    logic              ovf_nx;

    assign stall   = vld_p[LAST] & ~i_ready;
    assign o_ready = ~stall;

    assign b_cond   = (i_sub == MODE_SUB) ? ~i_data2 : i_data2;
    assign cin_cond = (i_sub == MODE_SUB) ? 1'b1 : i_carry;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SLICE-1:0] part_sum;
        logic             part_cout;

        if (k == 0) begin : g_head
            assign v_in[k]  = i_valid;
            assign a_in[k]  = i_data1;
            assign b_in[k]  = b_cond;
            assign s_in[k]  = '0;
            assign c_in[k]  = cin_cond;
            assign sa_in[k] = i_data1[WIDTH-1];
            assign sb_in[k] = b_cond[WIDTH-1];
        end else begin : g_link
            assign v_in[k]  = vld_p[k-1];
            assign a_in[k]  = a_p[k-1];
            assign b_in[k]  = b_p[k-1];
            assign s_in[k]  = sum_p[k-1];
            assign c_in[k]  = cy_p[k-1];
            assign sa_in[k] = sa_p[k-1];
            assign sb_in[k] = sb_p[k-1];
        end

        add_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a    (a_in[k][k*SLICE +: SLICE]),
            .b    (b_in[k][k*SLICE +: SLICE]),
            .cin  (c_in[k]),
            .sum  (part_sum),
            .cout (part_cout)
        );

        assign sum_nx[k] = put_slice(s_in[k], part_sum, k);
        assign cy_nx[k]  = part_cout;
    end

    // Final stage: signed overflow when like-signed operands give an opposite-signed result.
    assign ovf_nx = (sa_in[LAST] == sb_in[LAST]) && (sum_nx[LAST][WIDTH-1] != sa_in[LAST]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p  <= '0;
            ovf_p  <= 1'b0;
            zero_p <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                sum_p[k] <= '0;
                cy_p[k]  <= 1'b0;
                sa_p[k]  <= 1'b0;
                sb_p[k]  <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= v_in[k];
                // Data only moves with a valid beat so idle outputs keep their last values.
                if (v_in[k]) begin
                    a_p[k]   <= a_in[k];
                    b_p[k]   <= b_in[k];
                    sum_p[k] <= sum_nx[k];
                    cy_p[k]  <= cy_nx[k];
                    sa_p[k]  <= sa_in[k];
                    sb_p[k]  <= sb_in[k];
                end
            end
            if (v_in[LAST]) begin
                ovf_p  <= ovf_nx;
                zero_p <= ~|sum_nx[LAST];
            end
        end
    end

    assign o_valid    = vld_p[LAST];
    assign o_data     = sum_p[LAST];
    assign o_carry    = cy_p[LAST];
    assign o_overflow = ovf_p;
    assign o_zero     = zero_p;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed vector table, backpressured random stream with a
// scoreboard, mid-flight reset, and a single-stage instance for the latency-1 case.
module tb_pipe_addsub;

    localparam int W = 32;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic         i_valid = 1'b0;
    logic [W-1:0] i_data1 = '0;
    logic [W-1:0] i_data2 = '0;
    logic         i_carry = 1'b0;
    logic         i_sub = 1'b0;
    logic         i_ready = 1'b1;
    logic         o_ready, o_valid, o_carry, o_overflow, o_zero;
    logic [W-1:0] o_data;

    logic         i_ready32 = 1'b1;
    logic         o_ready32, o_valid32, o_carry32, o_overflow32, o_zero32;
    logic [W-1:0] o_data32;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    pipe_addsub #(.WIDTH(W), .SLICE(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data1(i_data1), .i_data2(i_data2), .i_carry(i_carry), .i_sub(i_sub),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_carry(o_carry),
        .o_overflow(o_overflow), .o_zero(o_zero)
    );

    pipe_addsub #(.WIDTH(W), .SLICE(32)) dut32 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready32),
        .i_data1(i_data1), .i_data2(i_data2), .i_carry(i_carry), .i_sub(i_sub),
        .o_valid(o_valid32), .i_ready(i_ready32), .o_data(o_data32), .o_carry(o_carry32),
        .o_overflow(o_overflow32), .o_zero(o_zero32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result packed as {data, carry, overflow, zero}.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         v;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        v    = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W-1:0], full[W], v, (full[W-1:0] == '0)};
    endfunction

    logic [W+2:0] sb[$];
    logic         in_fire = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W+2:0] prev_out = '0;
    int           out_cnt = 0;

    // Monitor on the falling edge: inputs and outputs are settled for the next rising edge.
    always @(negedge i_clk) begin
        if (i_rst) begin
            sb.delete();
            in_fire    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", o_valid, 1'b1);
                chk("stall_hold_out", {o_data, o_carry, o_overflow, o_zero}, prev_out);
            end
            chk("ready_vs_stall", o_ready, !(o_valid && !i_ready));
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", o_valid, 1'b0);
                end else begin
                    chk("sb_out", {o_data, o_carry, o_overflow, o_zero}, sb.pop_front());
                end
                out_cnt++;
            end
            in_fire = i_valid && o_ready;
            if (in_fire) sb.push_back(model(i_data1, i_data2, i_carry, i_sub));
            prev_stall = o_valid && !i_ready;
            prev_out   = {o_data, o_carry, o_overflow, o_zero};
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] d;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat32, guard, sent, cyc, start_cnt;
        logic [W-1:0] last_d;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h00000003, 32'h00000003, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'h00FFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h01000001, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{32'h00000010, 32'h00000003, 1'b1, 1'b1, 32'h0000000D, 1'b1, 1'b0, 1'b0};

        // Reset
        #2 i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_data", o_data, '0);
        chk("rst_carry", o_carry, 1'b0);
        chk("rst_ovf", o_overflow, 1'b0);
        chk("rst_zero", o_zero, 1'b0);
        chk("rst_valid32", o_valid32, 1'b0);

        // Directed vectors, latency on both depths
        last_d = '0;
        for (int i = 0; i < 10; i++) begin
            i_data1 = vecs[i].a; i_data2 = vecs[i].b;
            i_carry = vecs[i].cin; i_sub = vecs[i].sub;
            i_valid = 1'b1; i_ready = 1'b1;
            lat = 0; lat32 = 0;
            for (int c = 1; c <= 12 && lat == 0; c++) begin
                @(posedge i_clk); #1;
                if (c == 1) i_valid = 1'b0;
                if (o_valid32 && lat32 == 0) begin
                    lat32 = c;
                    chk("vec_data32", o_data32, vecs[i].d);
                    chk("vec_flags32", {o_carry32, o_overflow32, o_zero32, o_ready32},
                        {vecs[i].c, vecs[i].v, vecs[i].z, 1'b1});
                end
                if (o_valid) begin
                    lat = c;
                    chk("vec_data", o_data, vecs[i].d);
                    chk("vec_carry", o_carry, vecs[i].c);
                    chk("vec_ovf", o_overflow, vecs[i].v);
                    chk("vec_zero", o_zero, vecs[i].z);
                end
            end
            chk("vec_latency", lat, 4);
            chk("vec_latency32", lat32, 1);
            last_d = vecs[i].d;
        end

        // Idle output holds last result
        repeat (3) @(posedge i_clk);
        #1;
        chk("idle_valid", o_valid, 1'b0);
        chk("idle_hold_data", o_data, last_d);

        // Random stream under 3-on/2-off backpressure
        start_cnt = out_cnt;
        sent = 0; cyc = 0; guard = 0;
        i_data1 = $urandom; i_data2 = $urandom;
        i_carry = 1'($urandom_range(0, 1)); i_sub = 1'($urandom_range(0, 1));
        i_valid = 1'b1; i_ready = 1'b1;
        while (sent < 16 && guard < 300) begin
            @(posedge i_clk); #1;
            guard++;
            if (in_fire) begin
                sent++;
                i_data1 = $urandom; i_data2 = $urandom;
                i_carry = 1'($urandom_range(0, 1)); i_sub = 1'($urandom_range(0, 1));
            end
            if (sent >= 16) i_valid = 1'b0;
            cyc++;
            i_ready = ((cyc % 5) < 3);
        end
        chk("stream_sent", sent, 16);
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge i_clk); #1;
            guard++;
            cyc++;
            i_ready = ((cyc % 5) < 3);
        end
        chk("stream_count", out_cnt - start_cnt, 16);
        chk("stream_drained", sb.size(), 0);
        i_ready = 1'b1;
        @(posedge i_clk); #1;

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            i_data1 = 32'h00000100 + i; i_data2 = 32'h00000002;
            i_carry = 1'b0; i_sub = 1'b0; i_valid = 1'b1;
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        chk("rst_prefill_valid", o_valid, 1'b1);
        i_rst = 1'b1;
        #1;
        chk("rst_async_valid", o_valid, 1'b0);
        chk("rst_async_data", o_data, '0);
        chk("rst_async_flags", {o_carry, o_overflow, o_zero}, 3'b000);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk); #1;
            chk("rst_no_ghost", o_valid, 1'b0);
        end
        chk("rst_ready_after", o_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
